// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ valid/ready requesters into one push register,
// with an optional guard interval after each write so downstream logic can settle.

module reg_write_arbiter_chk #(
  parameter int NUM_REQ = 4
) (
  input logic               clk_i,
  input logic               rst_n,
  input logic [NUM_REQ-1:0] req_ready,
  input logic               push,
  input logic               busy
);
  a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_n)
    $onehot0(req_ready));
  a_ready_only_idle: assert property (@(posedge clk_i) disable iff (!rst_n)
    (req_ready != {NUM_REQ{1'b0}}) |-> !busy);
  a_push_while_busy: assert property (@(posedge clk_i) disable iff (!rst_n)
    push |-> busy);
  a_push_single: assert property (@(posedge clk_i) disable iff (!rst_n)
    push |=> !push);
endmodule

module reg_write_arbiter #(
  parameter int N        = 32,
  parameter int NUM_REQ  = 4,
  parameter int HOLD_CYC = 1,
  parameter int CNT_W    = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*N-1:0]       req_data_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic                       push_o,
  output logic [N-1:0]               data_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic                       busy_o,
  output logic [CNT_W-1:0]           wr_count_o
);
  localparam int              ID_W    = $clog2(NUM_REQ);
  localparam logic [ID_W-1:0] PTR_RST = ID_W'(NUM_REQ - 1);
  localparam logic [3:0]      HOLD_LD = 4'(HOLD_CYC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  logic [1:0]       rst_sync_r;
  logic             rst_n_s;
  state_t           state_r;
  state_t           state_next_s;
  logic [ID_W-1:0]  ptr_r;
  logic [ID_W-1:0]  grant_r;
  logic [ID_W-1:0]  win_idx_s;
  logic [ID_W-1:0]  cand_s;
  logic             win_found_s;
  logic             accept_s;
  logic [3:0]       hold_cnt_r;
  logic             push_r;
  logic             busy_r;
  logic [N-1:0]     data_r;
  logic [CNT_W-1:0] cnt_r;

  // Reset synchronizer: asserts with rst_i, releases two clock edges after rst_i rises
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  // Round-robin winner search starting just after the last granted requester
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {ID_W{1'b0}};
    cand_s      = {ID_W{1'b0}};
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s = ID_W'((int'(ptr_r) + i) % NUM_REQ);
      if (!win_found_s && req_valid_i[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // A handshake is only offered while idle and out of reset, so none can be lost
  assign accept_s = (state_r == IDLE) && win_found_s && rst_n_s;

  // One-hot accept strobe for the winning requester
  always_comb begin
    req_ready_o = {NUM_REQ{1'b0}};
    if (accept_s) begin
      req_ready_o[win_idx_s] = 1'b1;
    end else begin
      req_ready_o = {NUM_REQ{1'b0}};
    end
  end

  // Next-state logic for IDLE -> WRITE -> HOLD -> IDLE
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = WRITE;
        end else begin
          state_next_s = IDLE;
        end
      end
      WRITE: begin
        if (HOLD_CYC == 0) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt_r <= 4'd1) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = HOLD;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, grant bookkeeping and registered outputs
  always_ff @(posedge clk_i or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r    <= IDLE;
      ptr_r      <= PTR_RST;
      grant_r    <= {ID_W{1'b0}};
      hold_cnt_r <= 4'd0;
      push_r     <= 1'b0;
      busy_r     <= 1'b0;
      data_r     <= {N{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      push_r  <= accept_s;
      busy_r  <= (state_next_s != IDLE);
      if (accept_s) begin
        data_r  <= req_data_i[int'(win_idx_s)*N +: N];
        grant_r <= win_idx_s;
        ptr_r   <= win_idx_s;
        cnt_r   <= cnt_r + CNT_W'(1);
      end
      // Guard counter loads while writing and counts down through HOLD
      if (state_r == WRITE) begin
        hold_cnt_r <= HOLD_LD;
      end else if ((state_r == HOLD) && (hold_cnt_r != 4'd0)) begin
        hold_cnt_r <= hold_cnt_r - 4'd1;
      end
    end
  end

  assign push_o     = push_r;
  assign data_o     = data_r;
  assign grant_id_o = grant_r;
  assign busy_o     = busy_r;
  assign wr_count_o = cnt_r;

  reg_write_arbiter_chk #(.NUM_REQ(NUM_REQ)) u_chk (
    .clk_i     (clk_i),
    .rst_n     (rst_n_s),
    .req_ready (req_ready_o),
    .push      (push_o),
    .busy      (busy_o)
  );
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: instance A uses HOLD_CYC=1/CNT_W=16,
// instance B uses HOLD_CYC=0/CNT_W=4 for back-to-back and wrap scenarios.
module tb_reg_write_arbiter;
  typedef struct {
    logic [3:0] rdy;
    int         cyc;
  } hs_t;
  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    logic [15:0] cnt;
    int          cyc;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  logic         rst_a, rst_b;
  logic [3:0]   val_a, val_b, rdy_a, rdy_b;
  logic [127:0] dat_a, dat_b;
  logic         push_a, push_b, busy_a, busy_b;
  logic [31:0]  do_a, do_b;
  logic [1:0]   gid_a, gid_b;
  logic [15:0]  cnt_a;
  logic [3:0]   cnt_b;
  logic [31:0]  dtab [4];

  hs_t hs_qa[$], hs_qb[$];
  wr_t wr_qa[$], wr_qb[$];

  reg_write_arbiter #(.N(32), .NUM_REQ(4), .HOLD_CYC(1), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .req_valid_i(val_a), .req_data_i(dat_a),
    .req_ready_o(rdy_a), .push_o(push_a), .data_o(do_a), .grant_id_o(gid_a),
    .busy_o(busy_a), .wr_count_o(cnt_a));

  reg_write_arbiter #(.N(32), .NUM_REQ(4), .HOLD_CYC(0), .CNT_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .req_valid_i(val_b), .req_data_i(dat_b),
    .req_ready_o(rdy_b), .push_o(push_b), .data_o(do_b), .grant_id_o(gid_b),
    .busy_o(busy_b), .wr_count_o(cnt_b));

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic exp_hs_a(input int off, input logic [3:0] rdy);
    hs_t h;
    h.rdy = rdy; h.cyc = cyc + off;
    hs_qa.push_back(h);
  endtask

  task automatic exp_a(input int off, input logic [3:0] rdy, input logic [1:0] id,
                       input logic [31:0] d, input logic [15:0] c);
    wr_t w;
    exp_hs_a(off, rdy);
    w.id = id; w.data = d; w.cnt = c; w.cyc = cyc + off + 1;
    wr_qa.push_back(w);
  endtask

  task automatic exp_b(input int off, input logic [3:0] rdy, input logic [1:0] id,
                       input logic [31:0] d, input logic [15:0] c);
    hs_t h;
    wr_t w;
    h.rdy = rdy; h.cyc = cyc + off;
    hs_qb.push_back(h);
    w.id = id; w.data = d; w.cnt = c; w.cyc = cyc + off + 1;
    wr_qb.push_back(w);
  endtask

  task automatic reset_a();
    rst_a = 1'b0; val_a = 4'b0000;
    step(2);
    cmp("a_rst_push", 64'(push_a), 64'd0);
    cmp("a_rst_data", 64'(do_a), 64'd0);
    cmp("a_rst_grant", 64'(gid_a), 64'd0);
    cmp("a_rst_busy", 64'(busy_a), 64'd0);
    cmp("a_rst_count", 64'(cnt_a), 64'd0);
    rst_a = 1'b1;
    step(3);
  endtask

  task automatic reset_b();
    rst_b = 1'b0; val_b = 4'b0000;
    step(2);
    cmp("b_rst_push", 64'(push_b), 64'd0);
    cmp("b_rst_count", 64'(cnt_b), 64'd0);
    rst_b = 1'b1;
    step(3);
  endtask

  // Monitor A: every accept strobe and every push is matched against the scoreboard
  always @(negedge clk) begin
    hs_t h;
    wr_t w;
    if (rdy_a != 4'b0000) begin
      if (hs_qa.size() == 0) begin
        cmp("a_ready_unexpected", 64'(rdy_a), 64'd0);
      end else begin
        h = hs_qa.pop_front();
        cmp("a_ready", 64'(rdy_a), 64'(h.rdy));
        cmp("a_ready_cycle", 64'(cyc), 64'(h.cyc));
      end
    end
    if (push_a) begin
      if (wr_qa.size() == 0) begin
        cmp("a_push_unexpected", 64'(push_a), 64'd0);
      end else begin
        w = wr_qa.pop_front();
        cmp("a_push_grant", 64'(gid_a), 64'(w.id));
        cmp("a_push_data", 64'(do_a), 64'(w.data));
        cmp("a_push_count", 64'(cnt_a), 64'(w.cnt));
        cmp("a_push_cycle", 64'(cyc), 64'(w.cyc));
      end
    end
  end

  // Monitor B: same scoreboard check for the zero-guard, narrow-counter instance
  always @(negedge clk) begin
    hs_t h;
    wr_t w;
    if (rdy_b != 4'b0000) begin
      if (hs_qb.size() == 0) begin
        cmp("b_ready_unexpected", 64'(rdy_b), 64'd0);
      end else begin
        h = hs_qb.pop_front();
        cmp("b_ready", 64'(rdy_b), 64'(h.rdy));
        cmp("b_ready_cycle", 64'(cyc), 64'(h.cyc));
      end
    end
    if (push_b) begin
      if (wr_qb.size() == 0) begin
        cmp("b_push_unexpected", 64'(push_b), 64'd0);
      end else begin
        w = wr_qb.pop_front();
        cmp("b_push_grant", 64'(gid_b), 64'(w.id));
        cmp("b_push_data", 64'(do_b), 64'(w.data));
        cmp("b_push_count", 64'(cnt_b), 64'(w.cnt));
        cmp("b_push_cycle", 64'(cyc), 64'(w.cyc));
      end
    end
  end

  initial begin
    dtab[0] = 32'h0000_1111; dtab[1] = 32'h2222_0000;
    dtab[2] = 32'h3333_3333; dtab[3] = 32'h4444_4444;
    rst_a = 1'b1; rst_b = 1'b1;
    val_a = 4'b0000; val_b = 4'b0000;
    dat_a = 128'd0; dat_b = 128'd0;
    #1;
    reset_b();

    // Single requester, first transaction after reset
    reset_a();
    dat_a[31:0] = 32'hA5A5_A5A5;
    val_a = 4'b0001;
    exp_a(0, 4'b0001, 2'd0, 32'hA5A5_A5A5, 16'd1);
    step(1);
    val_a = 4'b0000;
    step(3);
    cmp("t1_count", 64'(cnt_a), 64'd1);

    // All requesters valid: grants 0,1,2,3,0 at 3-cycle spacing
    reset_a();
    for (int k = 0; k < 4; k++) dat_a[k*32 +: 32] = dtab[k];
    val_a = 4'b1111;
    exp_a(0,  4'b0001, 2'd0, 32'h0000_1111, 16'd1);
    exp_a(3,  4'b0010, 2'd1, 32'h2222_0000, 16'd2);
    exp_a(6,  4'b0100, 2'd2, 32'h3333_3333, 16'd3);
    exp_a(9,  4'b1000, 2'd3, 32'h4444_4444, 16'd4);
    exp_a(12, 4'b0001, 2'd0, 32'h0000_1111, 16'd5);
    step(13);
    val_a = 4'b0000;
    step(4);
    cmp("t2_count", 64'(cnt_a), 64'd5);
    cmp("t2_grant", 64'(gid_a), 64'd0);

    // Requester 1 raises valid during WRITE and drops it during HOLD
    val_a = 4'b0001;
    exp_a(0, 4'b0001, 2'd0, 32'h0000_1111, 16'd6);
    step(1);
    val_a = 4'b0010;
    step(1);
    val_a = 4'b0000;
    step(1);
    cmp("t6_busy_idle", 64'(busy_a), 64'd0);
    cmp("t6_no_ready", 64'(rdy_a), 64'd0);
    step(3);
    cmp("t6_busy_after", 64'(busy_a), 64'd0);
    cmp("t6_count", 64'(cnt_a), 64'd6);

    // Reset asserted mid-WRITE; requester 0 wins again afterwards
    reset_a();
    val_a = 4'b0011;
    exp_hs_a(0, 4'b0001);
    step(1);
    cmp("t4_push_before_rst", 64'(push_a), 64'd1);
    #1;
    rst_a = 1'b0; val_a = 4'b0000;
    #1;
    cmp("t4_push_async_drop", 64'(push_a), 64'd0);
    cmp("t4_count_async_clr", 64'(cnt_a), 64'd0);
    step(2);
    rst_a = 1'b1;
    step(3);
    val_a = 4'b0011;
    exp_a(0, 4'b0001, 2'd0, 32'h0000_1111, 16'd1);
    step(1);
    val_a = 4'b0000;
    step(3);

    // Requester 2 alone, no guard interval: ten back-to-back writes
    dat_b[64 +: 32] = 32'hC0DE_0002;
    val_b = 4'b0100;
    for (int i = 0; i < 10; i++) exp_b(2*i, 4'b0100, 2'd2, 32'hC0DE_0002, 16'(i + 1));
    step(19);
    val_b = 4'b0000;
    step(3);
    cmp("t3_count", 64'(cnt_b), 64'd10);

    // 17 writes into a 4-bit counter wrap it to 1
    reset_b();
    dat_b[31:0] = 32'h5A5A_0000;
    val_b = 4'b0001;
    for (int i = 0; i < 17; i++) exp_b(2*i, 4'b0001, 2'd0, 32'h5A5A_0000, 16'((i + 1) % 16));
    step(33);
    val_b = 4'b0000;
    step(3);
    cmp("t5_count_wrap", 64'(cnt_b), 64'd1);

    cmp("a_hs_left", 64'(hs_qa.size()), 64'd0);
    cmp("a_wr_left", 64'(wr_qa.size()), 64'd0);
    cmp("b_hs_left", 64'(hs_qb.size()), 64'd0);
    cmp("b_wr_left", 64'(wr_qb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
